// File: rtl/lr35902_oam_dma.sv
// lr35902_oam_dma: FF46 OAM DMA engine copying LEN bytes from a source page into OAM
module lr35902_oam_dma #(
  parameter int LEN = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        read,
  input  logic        write,
  output logic        active,
  output logic [15:0] adr_rd,
  output logic        rd,
  input  logic [7:0]  data_in,
  output logic [7:0]  adr_wr,
  output logic        wr,
  output logic [7:0]  data_out
);
  typedef enum logic [1:0] {IDLE, START, XFER, LAST} state_t;
  localparam logic [7:0] K_LAST = 8'(LEN - 1);
  localparam logic [1:0] DLY = 2'(START_DELAY);
  state_t state, state_nx;
  logic [7:0] src, k, k_nx, buffer, page;
  logic [1:0] dly, dly_nx;
  logic unused_read;
  assign unused_read = read;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      src    <= 8'h00;
      k      <= 8'h00;
      dly    <= 2'd0;
      buffer <= 8'h00;
    end else begin
      state <= state_nx;
      k     <= k_nx;
      dly   <= dly_nx;
      if (write) src <= din;
      if (state == XFER) buffer <= data_in;
    end
  end
  // k counts one past the final byte in LAST, so adr_wr = k-1 holds for every write cycle
  always_comb begin
    state_nx = state;
    k_nx     = k;
    dly_nx   = dly;
    if (write) begin
      state_nx = (state == IDLE && DLY == 2'd0) ? XFER : START;
      k_nx     = 8'h00;
      dly_nx   = DLY;
    end else if (state == START) begin
      dly_nx   = (dly == 2'd0) ? 2'd0 : dly - 2'd1;
      state_nx = (dly <= 2'd1) ? XFER : START;
    end else if (state == XFER) begin
      k_nx     = k + 8'd1;
      state_nx = (k == K_LAST) ? LAST : XFER;
    end else if (state == LAST) begin
      state_nx = IDLE;
    end
  end
  assign page     = (src < 8'hE0) ? src : src - 8'h20;
  assign dout     = src;
  assign active   = state == XFER || state == LAST;
  assign rd       = state == XFER;
  assign wr       = (state == XFER && k != 8'h00) || state == LAST;
  assign adr_rd   = rd ? {page, k} : 16'h0000;
  assign adr_wr   = wr ? k - 8'd1 : 8'h00;
  assign data_out = wr ? buffer : 8'h00;
endmodule

// File: tb/tb_lr35902_oam_dma.sv
// tb_lr35902_oam_dma: randomized scoreboard bench for the OAM DMA engine
module tb_lr35902_oam_dma;
  localparam int LEN = 160;
  localparam int SD = 1;
  typedef struct {int cyc; logic [15:0] adr; logic [7:0] dat;} ent_t;
  logic clk = 0, reset = 1, read = 1, write = 0;
  logic [7:0] din = 0, dout, data_in, adr_wr, data_out;
  logic [15:0] adr_rd;
  logic active, rd, wr;
  ent_t rdq[$], wrq[$];
  int cyc = 0, tests = 0, fails = 0;
  logic [7:0] src_m = 0;
  lr35902_oam_dma #(.LEN(LEN), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .din(din), .dout(dout), .read(read), .write(write),
    .active(active), .adr_rd(adr_rd), .rd(rd), .data_in(data_in),
    .adr_wr(adr_wr), .wr(wr), .data_out(data_out)
  );
  always #5 clk = ~clk;
  // source memory: each byte mixes its page and offset so page errors show up in data too
  assign data_in = adr_rd[7:0] ^ adr_rd[15:8] ^ 8'h5A;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask
  // reference: a register write schedules every read and write of the transfer on absolute cycles
  always @(posedge clk) begin
    logic [7:0] p;
    cyc++;
    if (!reset && write) begin
      src_m = din;
      p = (din >= 8'hE0) ? din - 8'h20 : din;
      while (rdq.size() > 0 && rdq[rdq.size()-1].cyc >= cyc) rdq.pop_back();
      while (wrq.size() > 0 && wrq[wrq.size()-1].cyc >= cyc) wrq.pop_back();
      for (int i = 0; i < LEN; i++) begin
        rdq.push_back('{cyc + SD + i, {p, 8'(i)}, 8'h00});
        wrq.push_back('{cyc + SD + 1 + i, {8'h00, 8'(i)}, 8'(i) ^ p ^ 8'h5A});
      end
    end
  end
  always @(negedge clk) begin
    logic er, ew;
    if (!reset) begin
      er = rdq.size() > 0 && rdq[0].cyc == cyc;
      ew = wrq.size() > 0 && wrq[0].cyc == cyc;
      if (rd || er) begin
        chk("rd", rd, er);
        if (er) begin
          chk("adr_rd", adr_rd, rdq[0].adr);
          rdq.pop_front();
        end
      end
      if (wr || ew) begin
        chk("wr", wr, ew);
        if (ew) begin
          chk("adr_wr", adr_wr, wrq[0].adr[7:0]);
          chk("data_out", data_out, wrq[0].dat);
          wrq.pop_front();
        end
      end
      if (active || er || ew) chk("active", active, er || ew);
      if (read) chk("dout", dout, src_m);
    end
  end
  task automatic wr_reg(input logic [7:0] v);
    @(negedge clk);
    din = v;
    write = 1;
    @(negedge clk);
    write = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 600 && (rdq.size() > 0 || wrq.size() > 0); i++) @(negedge clk);
    @(negedge clk);
    #1 chk("drain", rdq.size() + wrq.size(), 0);
    chk("idle_active", {active, rd, wr}, 3'b000);
  endtask
  initial begin
    logic [7:0] srcs[7];
    srcs = '{8'hC1, 8'h80, 8'hFE, 8'hE0, 8'hDF, 8'hFF, 8'h00};
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk("reset_outs", {active, rd, wr, adr_rd, adr_wr, data_out}, 35'h0);
      chk("reset_dout", dout, 8'h00);
    end
    foreach (srcs[i]) begin
      wr_reg(srcs[i]);
      drain();
    end
    for (int i = 0; i < 3; i++) begin
      wr_reg(8'($urandom));
      drain();
    end
    wr_reg(8'hC0);
    repeat (49) @(negedge clk);
    wr_reg(8'hD0);
    drain();
    for (int i = 0; i < 3; i++) begin
      wr_reg(8'($urandom));
      repeat ($urandom_range(1, 165)) @(negedge clk);
      wr_reg(8'($urandom));
      drain();
    end
    @(negedge clk);
    write = 1;
    for (int i = 0; i < 3; i++) begin
      din = 8'($urandom);
      @(negedge clk);
    end
    write = 0;
    drain();
    wr_reg(8'h9A);
    repeat (21) @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    rdq.delete();
    wrq.delete();
    src_m = 0;
    #1 chk("reset_mid", {active, rd, wr, adr_rd, adr_wr, data_out}, 35'h0);
    chk("reset_mid_dout", dout, 8'h00);
    @(negedge clk);
    #1 reset = 0;
    wr_reg(8'h45);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
